acc_control_unit: RTL and testbench
===================================

# acc_control_unit

Multi-cycle sequencer for the accumulator processor. It drives the load strobes of the PC, IR and accumulator registers and the memory request/acknowledge handshake for fetch, decode and execute. It counts retired instructions and traps into a fault state on a memory timeout. It sits between the instruction register's opcode field and the load/store register bank.

## Interface
- TIMEOUT, 15: maximum cycles a memory request may wait for `mem_ack` (1..255).
- CNT_W, 16: width of retired-instruction counter.
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high; returns block to IDLE.
- start  in  1  begins execution from IDLE (level, sampled at edge).
- opcode  in  3  IR[7:5], valid from the cycle after `ir_ld`.
- acc_zero  in  1  accumulator == 0 flag.
- mem_ack  in  1  memory completes request this cycle.
- mem_req  out  1  memory request; held until `mem_ack` or timeout.
- mem_we  out  1  write qualifier for `mem_req` (STORE only).
- addr_sel  out  1  0 = PC drives address, 1 = IR[4:0].
- pc_inc, pc_ld, ir_ld, acc_ld  out  1 each  one-cycle load strobes to the register bank.
- alu_op  out  2  00 PASS, 01 ADD, 10 SUB, 11 AND; valid whenever `acc_ld`=1.
- halted  out  1  in HALT state.
- fault  out  1  in FAULT state.
- retired  out  CNT_W  instructions completed, saturating.

## Operation
- Opcodes:
  - 000 LOAD
  - 001 STORE
  - 010 ADD
  - 011 SUB
  - 100 AND
  - 101 JMP
  - 110 JZ
  - 111 HALT
- States: IDLE, FETCH, DECODE, EXEC, HALT, FAULT.
- IDLE: all outputs 0. On `start`=1, go to FETCH.
- FETCH: `mem_req`=1, `addr_sel`=0, `mem_we`=0.
  - On `mem_ack`, assert `ir_ld`=1 and `pc_inc`=1 in the same cycle, then go to DECODE.
- DECODE: no memory request.
  - LOAD/STORE/ADD/SUB/AND: go to EXEC.
  - JMP: `pc_ld`=1, retire, go to FETCH.
  - JZ: `pc_ld`=`acc_zero`, retire, go to FETCH.
  - HALT: retire, go to HALT.
- EXEC: `mem_req`=1, `addr_sel`=1, `mem_we`=1 only for STORE.
  - On `mem_ack`: `acc_ld`=1 for LOAD/ADD/SUB/AND, with `alu_op` = PASS/ADD/SUB/AND respectively; no `acc_ld` for STORE.
  - Then retire and go to FETCH.
- HALT: `halted`=1; `start` is ignored; exit only via reset.
- FAULT: `fault`=1; all strobes 0; exit only via reset.
- Timeout: a wait counter clears on entry to FETCH/EXEC and increments each cycle `mem_req`=1 without `mem_ack`.
  - When the counter reaches TIMEOUT with no ack, `mem_req` drops and the next state is FAULT.
  - An ack arriving on the TIMEOUT-th wait cycle is accepted (ack has priority).
- Retire: `retired` increments by 1 on the edge leaving a retire cycle. It saturates at 2^CNT_W-1 with no wrap.
- Strobes are Mealy on (state, `mem_ack`, `opcode`, `acc_zero`) and never high for more than one cycle per instruction.

## Timing
- Reset value: state IDLE, wait counter 0, `retired`=0, all outputs 0.
- While `reset`=1, all outputs are forced to 0 combinationally. Reset mid-request abandons the request with no strobe.
- Zero-wait memory latency:
  - LOAD/STORE/ALU ops: 3 cycles.
  - JMP/JZ/HALT: 2 cycles.
- Each memory wait cycle adds 1 cycle.
- `mem_req` is high continuously from FETCH/EXEC entry until the ack cycle inclusive. On back-to-back EXEC→FETCH it stays high across the boundary.
- `opcode` is sampled only in DECODE and EXEC.

## Test plan
- Reset, then `start`=1, with memory returning LOAD(000) then HALT(111) and zero-wait acks:
  - `ir_ld` at cycles 1 and 4; `acc_ld`+PASS at cycle 3.
  - `halted`=1 from cycle 6; `retired`=2.
- JZ with `acc_zero`=1: `pc_ld`=1 in DECODE. Same with `acc_zero`=0: `pc_ld`=0 and `pc_inc` only; `retired` +1 each.
- STORE with `mem_ack` delayed 3 cycles: `mem_req`=`mem_we`=`addr_sel`=1 held for 4 cycles; no `acc_ld`; 6-cycle instruction.
- TIMEOUT=4, ack never arrives in FETCH: `fault`=1 on the cycle after the 4th wait cycle. Ack on the 4th wait cycle instead: normal DECODE.
- Assert `reset` during an EXEC wait: all outputs 0 that cycle, IDLE next, `retired` cleared; `start` again fetches normally.
- CNT_W=2, run 5 JMP instructions: `retired` reads 1,2,3,3,3.

Source files
------------

// File: rtl/acc_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : acc_control_unit
// Purpose  : Multi-cycle fetch/decode/execute sequencer for the accumulator
//            processor. It generates the PC/IR/ACC load strobes and the
//            memory request handshake, counts retired instructions
//            (saturating), and traps into FAULT on a memory timeout.
// Ports    :
//   clock     in   system clock, rising edge
//   reset     in   synchronous active-high reset; also masks all outputs
//   start     in   leave IDLE and begin fetching
//   opcode    in   IR[7:5], meaningful in DECODE and EXEC only
//   acc_zero  in   accumulator-is-zero flag, used by JZ
//   mem_ack   in   memory completes the outstanding request this cycle
//   mem_req   out  memory request, held until ack or timeout
//   mem_we    out  write qualifier for mem_req (STORE execute)
//   addr_sel  out  0 = PC drives address, 1 = IR[4:0]
//   pc_inc    out  PC increment strobe
//   pc_ld     out  PC load strobe (JMP, taken JZ)
//   ir_ld     out  IR load strobe
//   acc_ld    out  accumulator load strobe
//   alu_op    out  00 PASS, 01 ADD, 10 SUB, 11 AND (valid with acc_ld)
//   halted    out  sequencer is in HALT
//   fault     out  sequencer is in FAULT
//   retired   out  retired-instruction count, saturating
// Revision : 1.0 - initial release
// ============================================================================
module acc_control_unit #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic             acc_zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             pc_inc,
    output logic             pc_ld,
    output logic             ir_ld,
    output logic             acc_ld,
    output logic [1:0]       alu_op,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [2:0] c_op_load  = 3'b000;
    localparam logic [2:0] c_op_store = 3'b001;
    localparam logic [2:0] c_op_add   = 3'b010;
    localparam logic [2:0] c_op_sub   = 3'b011;
    localparam logic [2:0] c_op_and   = 3'b100;
    localparam logic [2:0] c_op_jmp   = 3'b101;
    localparam logic [2:0] c_op_jz    = 3'b110;
    localparam logic [2:0] c_op_halt  = 3'b111;

    localparam logic [1:0] c_alu_pass = 2'b00;
    localparam logic [1:0] c_alu_add  = 2'b01;
    localparam logic [1:0] c_alu_sub  = 2'b10;
    localparam logic [1:0] c_alu_and  = 2'b11;

    // TIMEOUT is limited to 1..255, so eight bits always hold the count.
    // The wait counter holds the number of ack-less request cycles already
    // completed; when it equals TIMEOUT-1 the current cycle is the last
    // permitted one.
    localparam logic [7:0] c_wait_last = 8'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Registers and combinational signals
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_wait;
    logic [CNT_W-1:0] r_retired;

    logic             w_wait_inc;
    logic             w_retire;
    logic             w_mem_req;
    logic             w_mem_we;
    logic             w_addr_sel;
    logic             w_pc_inc;
    logic             w_pc_ld;
    logic             w_ir_ld;
    logic             w_acc_ld;
    logic [1:0]       w_alu_op;
    logic             w_halted;
    logic             w_fault;

    // ------------------------------------------------------------------
    // State, wait counter and retire counter
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_wait    <= 8'd0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            // Anything other than a continuing wait (ack, timeout, or a
            // non-memory state) leaves the counter at zero, so every entry
            // into FETCH/EXEC starts a fresh count, including the
            // back-to-back EXEC->FETCH case.
            if (w_wait_inc) begin
                r_wait <= r_wait + 8'd1;
            end else begin
                r_wait <= 8'd0;
            end
            if (w_retire && (r_retired != c_cnt_max)) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and Mealy output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        w_wait_inc = 1'b0;
        w_retire   = 1'b0;
        w_mem_req  = 1'b0;
        w_mem_we   = 1'b0;
        w_addr_sel = 1'b0;
        w_pc_inc   = 1'b0;
        w_pc_ld    = 1'b0;
        w_ir_ld    = 1'b0;
        w_acc_ld   = 1'b0;
        w_alu_op   = c_alu_pass;
        w_halted   = 1'b0;
        w_fault    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_FETCH;
                end
            end

            S_FETCH: begin
                w_mem_req = 1'b1;
                if (mem_ack) begin
                    // Ack wins even on the last permitted wait cycle.
                    w_ir_ld  = 1'b1;
                    w_pc_inc = 1'b1;
                    w_next   = S_DECODE;
                end else if (r_wait == c_wait_last) begin
                    w_next = S_FAULT;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end

            S_DECODE: begin
                case (opcode)
                    c_op_load, c_op_store, c_op_add, c_op_sub, c_op_and: begin
                        w_next = S_EXEC;
                    end
                    c_op_jmp: begin
                        w_pc_ld  = 1'b1;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                    c_op_jz: begin
                        w_pc_ld  = acc_zero;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                    c_op_halt: begin
                        w_retire = 1'b1;
                        w_next   = S_HALT;
                    end
                    default: begin
                        w_next = S_FAULT;
                    end
                endcase
            end

            S_EXEC: begin
                w_mem_req  = 1'b1;
                w_addr_sel = 1'b1;
                w_mem_we   = (opcode == c_op_store);
                if (mem_ack) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                    case (opcode)
                        c_op_load: begin
                            w_acc_ld = 1'b1;
                            w_alu_op = c_alu_pass;
                        end
                        c_op_add: begin
                            w_acc_ld = 1'b1;
                            w_alu_op = c_alu_add;
                        end
                        c_op_sub: begin
                            w_acc_ld = 1'b1;
                            w_alu_op = c_alu_sub;
                        end
                        c_op_and: begin
                            w_acc_ld = 1'b1;
                            w_alu_op = c_alu_and;
                        end
                        default: begin
                            // STORE completes without touching the ACC.
                        end
                    endcase
                end else if (r_wait == c_wait_last) begin
                    w_next = S_FAULT;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end

            S_HALT: begin
                w_halted = 1'b1;
            end

            S_FAULT: begin
                w_fault = 1'b1;
            end

            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: reset forces everything low in the same cycle, so a
    // request abandoned by reset never produces a strobe.
    // ------------------------------------------------------------------
    assign mem_req  = w_mem_req  & ~reset;
    assign mem_we   = w_mem_we   & ~reset;
    assign addr_sel = w_addr_sel & ~reset;
    assign pc_inc   = w_pc_inc   & ~reset;
    assign pc_ld    = w_pc_ld    & ~reset;
    assign ir_ld    = w_ir_ld    & ~reset;
    assign acc_ld   = w_acc_ld   & ~reset;
    assign alu_op   = reset ? 2'b00 : w_alu_op;
    assign halted   = w_halted   & ~reset;
    assign fault    = w_fault    & ~reset;
    assign retired  = reset ? '0 : r_retired;

endmodule
`default_nettype wire

// File: tb/tb_acc_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_control_unit
// Purpose  : Directed self-checking bench for acc_control_unit, built with
//            TIMEOUT=4 and CNT_W=2 so timeout and saturation are reachable.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acc_control_unit;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 2;

    // Output vector bit positions:
    // [10]req [9]we [8]addr_sel [7]pc_inc [6]pc_ld [5]ir_ld [4]acc_ld
    // [3:2]alu_op [1]halted [0]fault
    localparam logic [10:0] c_none = 11'h000;
    localparam logic [10:0] c_req  = 11'h400;
    localparam logic [10:0] c_we   = 11'h200;
    localparam logic [10:0] c_as   = 11'h100;
    localparam logic [10:0] c_inc  = 11'h080;
    localparam logic [10:0] c_pld  = 11'h040;
    localparam logic [10:0] c_irl  = 11'h020;
    localparam logic [10:0] c_acl  = 11'h010;
    localparam logic [10:0] c_add  = 11'h004;
    localparam logic [10:0] c_sub  = 11'h008;
    localparam logic [10:0] c_and  = 11'h00C;
    localparam logic [10:0] c_hlt  = 11'h002;
    localparam logic [10:0] c_flt  = 11'h001;
    localparam logic [10:0] c_ftch = c_req | c_inc | c_irl;

    localparam logic [2:0] LD = 3'b000, ST = 3'b001, AD = 3'b010, SB = 3'b011;
    localparam logic [2:0] AN = 3'b100, JP = 3'b101, JZ = 3'b110, HT = 3'b111;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       opcode = 3'b000;
    logic             acc_zero = 1'b0;
    logic             mem_ack = 1'b0;
    logic             mem_req, mem_we, addr_sel, pc_inc, pc_ld, ir_ld, acc_ld;
    logic [1:0]       alu_op;
    logic             halted, fault;
    logic [CNT_W-1:0] retired;
    logic [10:0]      outs;

    int n_tests = 0;
    int n_fail  = 0;

    acc_control_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .opcode   (opcode),
        .acc_zero (acc_zero),
        .mem_ack  (mem_ack),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .addr_sel (addr_sel),
        .pc_inc   (pc_inc),
        .pc_ld    (pc_ld),
        .ir_ld    (ir_ld),
        .acc_ld   (acc_ld),
        .alu_op   (alu_op),
        .halted   (halted),
        .fault    (fault),
        .retired  (retired)
    );

    always #5 clock = ~clock;

    assign outs = {mem_req, mem_we, addr_sel, pc_inc, pc_ld, ir_ld, acc_ld,
                   alu_op, halted, fault};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: inputs driven at the falling edge, outputs checked
    // 1 time unit later, state advances at the following rising edge.
    task automatic cyc(input string tag, input logic s, input logic a,
                       input logic [2:0] op, input logic z, input logic [10:0] exp);
        @(negedge clock);
        start = s; mem_ack = a; opcode = op; acc_zero = z;
        #1;
        chk(tag, {21'd0, outs}, {21'd0, exp});
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        reset = 1'b1; start = 1'b0; mem_ack = 1'b0;
        #1;
        chk(tag, {21'd0, outs}, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    initial begin
        // ---------------- Reset state --------------------------------
        do_reset("rst_outs");
        cyc("rst_idle", 0, 0, LD, 0, c_none);
        chk("rst_retired", {30'd0, retired}, 32'd0);

        // ---------------- LOAD then HALT, zero wait -----------------
        cyc("lh_c0_idle",   1, 0, LD, 0, c_none);
        cyc("lh_c1_fetch",  0, 1, LD, 0, c_ftch);
        cyc("lh_c2_dec",    0, 0, LD, 0, c_none);
        cyc("lh_c3_exec",   0, 1, LD, 0, c_req | c_as | c_acl);
        cyc("lh_c4_fetch",  0, 1, HT, 0, c_ftch);
        chk("lh_ret1", {30'd0, retired}, 32'd1);
        cyc("lh_c5_dec",    0, 0, HT, 0, c_none);
        cyc("lh_c6_halt",   1, 0, HT, 0, c_hlt);
        chk("lh_ret2", {30'd0, retired}, 32'd2);
        cyc("lh_c7_halt",   1, 1, LD, 0, c_hlt);

        // ---------------- JZ taken / not taken ----------------------
        do_reset("jz_rst");
        cyc("jz_idle",      1, 0, JZ, 1, c_none);
        cyc("jz_fetch1",    0, 1, JZ, 1, c_ftch);
        cyc("jz_dec_taken", 0, 0, JZ, 1, c_pld);
        cyc("jz_fetch2",    0, 1, JZ, 0, c_ftch);
        chk("jz_ret1", {30'd0, retired}, 32'd1);
        cyc("jz_dec_not",   0, 0, JZ, 0, c_none);
        cyc("jz_fetch3",    0, 0, JZ, 0, c_req);
        chk("jz_ret2", {30'd0, retired}, 32'd2);

        // ---------------- STORE with 3 wait cycles ------------------
        do_reset("st_rst");
        cyc("st_idle",      1, 0, ST, 0, c_none);
        cyc("st_fetch",     0, 1, ST, 0, c_ftch);
        cyc("st_dec",       0, 0, ST, 0, c_none);
        cyc("st_wait1",     0, 0, ST, 0, c_req | c_we | c_as);
        cyc("st_wait2",     0, 0, ST, 0, c_req | c_we | c_as);
        cyc("st_wait3",     0, 0, ST, 0, c_req | c_we | c_as);
        cyc("st_ack",       0, 1, ST, 0, c_req | c_we | c_as);
        cyc("st_next_fetch",0, 0, ST, 0, c_req);
        chk("st_ret", {30'd0, retired}, 32'd1);

        // ---------------- ALU ops, counter saturation ---------------
        do_reset("alu_rst");
        cyc("alu_idle",     1, 0, AD, 0, c_none);
        cyc("add_fetch",    0, 1, AD, 0, c_ftch);
        cyc("add_dec",      0, 0, AD, 0, c_none);
        cyc("add_exec",     0, 1, AD, 0, c_req | c_as | c_acl | c_add);
        cyc("sub_fetch",    0, 1, SB, 0, c_ftch);
        cyc("sub_dec",      0, 0, SB, 0, c_none);
        cyc("sub_exec",     0, 1, SB, 0, c_req | c_as | c_acl | c_sub);
        cyc("and_fetch",    0, 1, AN, 0, c_ftch);
        cyc("and_dec",      0, 0, AN, 0, c_none);
        cyc("and_exec",     0, 1, AN, 0, c_req | c_as | c_acl | c_and);
        cyc("alu_fetch4",   0, 1, HT, 0, c_ftch);
        chk("alu_ret3", {30'd0, retired}, 32'd3);
        cyc("alu_dec_halt", 0, 0, HT, 0, c_none);
        cyc("alu_halt",     0, 0, HT, 0, c_hlt);
        chk("alu_ret_sat", {30'd0, retired}, 32'd3);

        // ---------------- FETCH timeout -> FAULT --------------------
        do_reset("to_rst");
        cyc("to_idle",      1, 0, LD, 0, c_none);
        cyc("to_w1",        0, 0, LD, 0, c_req);
        cyc("to_w2",        0, 0, LD, 0, c_req);
        cyc("to_w3",        0, 0, LD, 0, c_req);
        cyc("to_w4",        0, 0, LD, 0, c_req);
        cyc("to_fault",     1, 1, LD, 0, c_flt);
        cyc("to_fault2",    1, 0, LD, 0, c_flt);

        // ---------------- Ack on the 4th wait cycle -----------------
        do_reset("ack4_rst");
        cyc("ack4_idle",    1, 0, JP, 0, c_none);
        cyc("ack4_w1",      0, 0, JP, 0, c_req);
        cyc("ack4_w2",      0, 0, JP, 0, c_req);
        cyc("ack4_w3",      0, 0, JP, 0, c_req);
        cyc("ack4_w4ack",   0, 1, JP, 0, c_ftch);
        cyc("ack4_dec_jmp", 0, 0, JP, 0, c_pld);
        // EXEC timeout as well
        cyc("xto_fetch",    0, 1, AD, 0, c_ftch);
        cyc("xto_dec",      0, 0, AD, 0, c_none);
        cyc("xto_w1",       0, 0, AD, 0, c_req | c_as);
        cyc("xto_w2",       0, 0, AD, 0, c_req | c_as);
        cyc("xto_w3",       0, 0, AD, 0, c_req | c_as);
        cyc("xto_w4",       0, 0, AD, 0, c_req | c_as);
        cyc("xto_fault",    0, 1, AD, 0, c_flt);

        // ---------------- Reset during EXEC wait --------------------
        do_reset("rx_rst");
        cyc("rx_idle",      1, 0, JP, 0, c_none);
        cyc("rx_fetch1",    0, 1, JP, 0, c_ftch);
        cyc("rx_dec_jmp",   0, 0, JP, 0, c_pld);
        cyc("rx_fetch2",    0, 1, LD, 0, c_ftch);
        cyc("rx_dec_ld",    0, 0, LD, 0, c_none);
        cyc("rx_exec_wait", 0, 0, LD, 0, c_req | c_as);
        chk("rx_ret_before", {30'd0, retired}, 32'd1);
        @(negedge clock);
        reset = 1'b1; mem_ack = 1'b1;
        #1;
        chk("rx_rst_outs", {21'd0, outs}, 32'd0);
        chk("rx_rst_ret", {30'd0, retired}, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        cyc("rx_idle_after", 0, 0, LD, 0, c_none);
        chk("rx_ret_clr", {30'd0, retired}, 32'd0);
        cyc("rx_restart",   1, 0, LD, 0, c_none);
        cyc("rx_refetch",   0, 1, LD, 0, c_ftch);

        // ---------------- 5 JMPs, CNT_W=2 saturation ----------------
        do_reset("jm_rst");
        cyc("jm_idle",      1, 0, JP, 0, c_none);
        cyc("jm_f0",        0, 1, JP, 0, c_ftch);
        cyc("jm_d1",        0, 0, JP, 0, c_pld);
        cyc("jm_f1",        0, 1, JP, 0, c_ftch);
        chk("jm_ret1", {30'd0, retired}, 32'd1);
        cyc("jm_d2",        0, 0, JP, 0, c_pld);
        cyc("jm_f2",        0, 1, JP, 0, c_ftch);
        chk("jm_ret2", {30'd0, retired}, 32'd2);
        cyc("jm_d3",        0, 0, JP, 0, c_pld);
        cyc("jm_f3",        0, 1, JP, 0, c_ftch);
        chk("jm_ret3", {30'd0, retired}, 32'd3);
        cyc("jm_d4",        0, 0, JP, 0, c_pld);
        cyc("jm_f4",        0, 1, JP, 0, c_ftch);
        chk("jm_ret4", {30'd0, retired}, 32'd3);
        cyc("jm_d5",        0, 0, JP, 0, c_pld);
        cyc("jm_f5",        0, 0, JP, 0, c_req);
        chk("jm_ret5", {30'd0, retired}, 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
